// File: rtl/pc_ras_unit_if.sv
// Control/status bundle for pc_ras_unit.
//   master: drives halt_sig, resume, stall, branch_en/target, call_en/target, ret_en;
//           observes PC_out, ras_empty, ras_full, halted, fault.
//   slave : the PC/RAS unit itself (mirror directions).
interface pc_ras_unit_if #(
  parameter int unsigned WIDTH = 16
);
  logic             halt_sig;
  logic             resume;
  logic             stall;
  logic             branch_en;
  logic [WIDTH-1:0] branch_target;
  logic             call_en;
  logic [WIDTH-1:0] call_target;
  logic             ret_en;
  logic [WIDTH-1:0] PC_out;
  logic             ras_empty;
  logic             ras_full;
  logic             halted;
  logic             fault;

  modport master (
    output halt_sig, resume, stall, branch_en, branch_target,
           call_en, call_target, ret_en,
    input  PC_out, ras_empty, ras_full, halted, fault
  );

  modport slave (
    input  halt_sig, resume, stall, branch_en, branch_target,
           call_en, call_target, ret_en,
    output PC_out, ras_empty, ras_full, halted, fault
  );
endinterface

// File: rtl/pc_ras_unit.sv
// Program counter with a return-address stack and a RUN/HALTED/FAULT control FSM.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : pc_ras_unit_if.slave -- control requests in; PC_out and
//              stack/FSM status out (all registered)
// Priority in RUN: halt_sig > stall > ret_en > call_en > branch_en > sequential.
module pc_ras_unit #(
  parameter int unsigned      WIDTH     = 16,
  parameter int unsigned      STEP      = 2,
  parameter int unsigned      RAS_DEPTH = 4,
  parameter logic [WIDTH-1:0] RESET_VEC = '0
) (
  input  logic          clk,
  input  logic          rst,
  pc_ras_unit_if.slave  bus
);

  localparam int unsigned DEPTH_W = $clog2(RAS_DEPTH + 1);
  localparam int unsigned PTR_W   = $clog2(RAS_DEPTH);
  localparam logic [WIDTH-1:0]   STEP_V = WIDTH'(STEP);
  localparam logic [DEPTH_W-1:0] FULL_V = DEPTH_W'(RAS_DEPTH);

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_HALTED = 2'd1,
    ST_FAULT  = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   pc_q, pc_d;
  logic [DEPTH_W-1:0] depth_q, depth_d;
  logic [WIDTH-1:0]   stack_q [RAS_DEPTH];
  logic [WIDTH-1:0]   stack_d [RAS_DEPTH];
  logic               empty_q, empty_d;
  logic               full_q, full_d;
  logic               halted_q, halted_d;
  logic               fault_q, fault_d;

  logic [PTR_W-1:0]   top_idx;
  logic [PTR_W-1:0]   push_idx;

  // Stack grows upward; depth_q is the next free slot.
  assign top_idx  = PTR_W'(depth_q - DEPTH_W'(1));
  assign push_idx = PTR_W'(depth_q);

  // Next-state, next-PC and stack update.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    depth_d = depth_q;
    stack_d = stack_q;

    case (state_q)
      ST_RUN: begin
        if (bus.halt_sig) begin
          state_d = ST_HALTED;
        end else if (bus.stall) begin
          state_d = ST_RUN;
        end else if (bus.ret_en) begin
          // ret_en outranks call_en when both are asserted.
          if (depth_q == '0) begin
            state_d = ST_FAULT;
          end else begin
            pc_d    = stack_q[top_idx];
            depth_d = depth_q - DEPTH_W'(1);
          end
        end else if (bus.call_en) begin
          if (depth_q == FULL_V) begin
            state_d = ST_FAULT;
          end else begin
            stack_d[push_idx] = pc_q + STEP_V;
            pc_d              = bus.call_target;
            depth_d           = depth_q + DEPTH_W'(1);
          end
        end else if (bus.branch_en) begin
          pc_d = bus.branch_target;
        end else begin
          pc_d = pc_q + STEP_V;
        end
      end
      ST_HALTED: begin
        // resume also overrides a concurrent halt_sig.
        if (bus.resume) state_d = ST_RUN;
      end
      ST_FAULT: begin
        state_d = ST_FAULT;
      end
      default: begin
        state_d = ST_FAULT;
      end
    endcase

    empty_d  = (depth_d == '0);
    full_d   = (depth_d == FULL_V);
    halted_d = (state_d == ST_HALTED);
    fault_d  = (state_d == ST_FAULT);
  end

  // State registers; reset discards any stack contents.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_RUN;
      pc_q     <= RESET_VEC;
      depth_q  <= '0;
      for (int i = 0; i < int'(RAS_DEPTH); i++) stack_q[i] <= '0;
      empty_q  <= 1'b1;
      full_q   <= 1'b0;
      halted_q <= 1'b0;
      fault_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      depth_q  <= depth_d;
      stack_q  <= stack_d;
      empty_q  <= empty_d;
      full_q   <= full_d;
      halted_q <= halted_d;
      fault_q  <= fault_d;
    end
  end

  assign bus.PC_out    = pc_q;
  assign bus.ras_empty = empty_q;
  assign bus.ras_full  = full_q;
  assign bus.halted    = halted_q;
  assign bus.fault     = fault_q;

endmodule

// File: tb/tb_pc_ras_unit.sv
// Bench for pc_ras_unit: a queue-based reference model checked every negedge,
// plus hand-computed literal checks along directed scenarios.
module tb_pc_ras_unit;
  localparam int unsigned W     = 16;
  localparam int unsigned STEP  = 2;
  localparam int unsigned DEPTH = 4;
  localparam int          RVEC  = 0;
  localparam int          MASK  = (1 << W) - 1;

  logic clk = 1'b0;
  logic rst;
  bit   armed = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

  pc_ras_unit_if #(.WIDTH(W)) bus();

  pc_ras_unit #(
    .WIDTH(W), .STEP(STEP), .RAS_DEPTH(DEPTH), .RESET_VEC(W'(RVEC))
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: 0 = RUN, 1 = HALTED, 2 = FAULT.
  int m_pc    = RVEC;
  int m_state = 0;
  int m_stack[$];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_pc    = RVEC;
      m_state = 0;
      m_stack.delete();
    end else if (m_state == 0) begin
      if (bus.halt_sig) m_state = 1;
      else if (bus.stall) m_state = 0;
      else if (bus.ret_en) begin
        if (m_stack.size() == 0) m_state = 2;
        else m_pc = m_stack.pop_back();
      end else if (bus.call_en) begin
        if (m_stack.size() == int'(DEPTH)) m_state = 2;
        else begin
          m_stack.push_back((m_pc + int'(STEP)) & MASK);
          m_pc = int'(bus.call_target);
        end
      end else if (bus.branch_en) m_pc = int'(bus.branch_target);
      else m_pc = (m_pc + int'(STEP)) & MASK;
    end else if (m_state == 1) begin
      if (bus.resume) m_state = 0;
    end
  end

  // Model-vs-DUT comparison every cycle, away from the active edge.
  always @(negedge clk) begin
    if (armed) begin
      chk("m_pc",     int'(bus.PC_out),    m_pc);
      chk("m_empty",  int'(bus.ras_empty), (m_stack.size() == 0) ? 1 : 0);
      chk("m_full",   int'(bus.ras_full),  (m_stack.size() == int'(DEPTH)) ? 1 : 0);
      chk("m_halted", int'(bus.halted),    (m_state == 1) ? 1 : 0);
      chk("m_fault",  int'(bus.fault),     (m_state == 2) ? 1 : 0);
    end
  end

  task automatic idle();
    bus.halt_sig = 0; bus.resume = 0; bus.stall = 0;
    bus.branch_en = 0; bus.call_en = 0; bus.ret_en = 0;
    bus.branch_target = '0; bus.call_target = '0;
  endtask

  task automatic edge_();
    @(posedge clk); #1;
  endtask

  // Assert reset between edges, check it acts without a clock, release after one edge.
  task automatic do_reset();
    idle();
    rst = 1'b1;
    #1;
    chk("rst_pc",     int'(bus.PC_out),    RVEC);
    chk("rst_empty",  int'(bus.ras_empty), 1);
    chk("rst_full",   int'(bus.ras_full),  0);
    chk("rst_halted", int'(bus.halted),    0);
    chk("rst_fault",  int'(bus.fault),     0);
    edge_();
    rst = 1'b0;
  endtask

  task automatic call(input int tgt);
    idle(); bus.call_en = 1; bus.call_target = W'(tgt); edge_();
  endtask

  initial begin
    idle();
    rst = 1'b1;
    #2;
    armed = 1'b1;
    do_reset();

    // Sequential counting out of reset
    chk("r40_pc0", int'(bus.PC_out), 0);
    idle(); edge_(); chk("r40_pc1", int'(bus.PC_out), 2);
    edge_();         chk("r40_pc2", int'(bus.PC_out), 4);
    edge_();         chk("r40_pc3", int'(bus.PC_out), 6);
    chk("r40_empty", int'(bus.ras_empty), 1);

    // Call / return round trip
    bus.branch_en = 1; bus.branch_target = 16'h0010; edge_();
    chk("r41_br", int'(bus.PC_out), 16'h0010);
    call(16'h0100);  chk("r41_call", int'(bus.PC_out), 16'h0100);
    chk("r41_nempty", int'(bus.ras_empty), 0);
    idle(); edge_(); chk("r41_i1", int'(bus.PC_out), 16'h0102);
    edge_();         chk("r41_i2", int'(bus.PC_out), 16'h0104);
    bus.ret_en = 1; edge_();
    chk("r41_ret", int'(bus.PC_out), 16'h0012);
    chk("r41_empty", int'(bus.ras_empty), 1);

    // call_en and ret_en together: ret wins
    call(16'h0300);  chk("cr_call", int'(bus.PC_out), 16'h0300);
    idle(); bus.ret_en = 1; bus.call_en = 1; bus.call_target = 16'h0900; edge_();
    chk("cr_ret", int'(bus.PC_out), 16'h0014);
    chk("cr_empty", int'(bus.ras_empty), 1);

    // Overflow into FAULT
    call(16'h0200); call(16'h0300); call(16'h0400);
    chk("r42_nfull", int'(bus.ras_full), 0);
    call(16'h0500);
    chk("r42_full", int'(bus.ras_full), 1);
    chk("r42_pc4", int'(bus.PC_out), 16'h0500);
    call(16'h0600);
    chk("r42_fault", int'(bus.fault), 1);
    chk("r42_frz", int'(bus.PC_out), 16'h0500);
    idle(); bus.ret_en = 1; edge_();
    chk("r42_frz2", int'(bus.PC_out), 16'h0500);
    chk("r42_flt2", int'(bus.fault), 1);
    do_reset();
    chk("r42_clr", int'(bus.fault), 0);

    // Underflow into FAULT
    bus.ret_en = 1; edge_();
    chk("r43_fault", int'(bus.fault), 1);
    chk("r43_pc", int'(bus.PC_out), 0);
    do_reset();

    // Halt / resume
    idle(); edge_(); edge_();
    chk("r44_pc4", int'(bus.PC_out), 4);
    bus.halt_sig = 1; bus.branch_en = 1; bus.branch_target = 16'h0080;
    for (int i = 0; i < 3; i++) begin
      edge_();
      chk("r44_halted", int'(bus.halted), 1);
      chk("r44_hold", int'(bus.PC_out), 4);
    end
    idle(); bus.resume = 1; edge_();
    chk("r44_run", int'(bus.halted), 0);
    chk("r44_nochg", int'(bus.PC_out), 4);
    idle(); edge_();
    chk("r44_seq", int'(bus.PC_out), 6);

    // resume beats halt_sig while HALTED
    bus.halt_sig = 1; edge_();
    chk("r33_h", int'(bus.halted), 1);
    bus.resume = 1; edge_();
    chk("r33_r", int'(bus.halted), 0);
    chk("r33_pc", int'(bus.PC_out), 6);
    idle(); edge_();
    chk("r33_seq", int'(bus.PC_out), 8);

    // Reset while HALTED
    bus.halt_sig = 1; edge_();
    do_reset();

    // Wrap, stall
    bus.branch_en = 1; bus.branch_target = 16'hFFFE; edge_();
    chk("r45_br", int'(bus.PC_out), 16'hFFFE);
    idle(); edge_();
    chk("r45_wrap", int'(bus.PC_out), 0);
    bus.stall = 1; bus.call_en = 1; bus.call_target = 16'h1234; edge_();
    chk("r45_stall", int'(bus.PC_out), 0);
    chk("r45_empty", int'(bus.ras_empty), 1);
    idle(); bus.stall = 1; bus.ret_en = 1; edge_();
    chk("st_nofault", int'(bus.fault), 0);
    idle(); edge_();
    chk("st_seq", int'(bus.PC_out), 2);

    // Nested LIFO order
    call(16'h0040); call(16'h0080);
    idle(); bus.ret_en = 1; edge_();
    chk("lifo1", int'(bus.PC_out), 16'h0042);
    edge_();
    chk("lifo2", int'(bus.PC_out), 16'h0004);
    chk("lifo_empty", int'(bus.ras_empty), 1);

    idle();
    @(negedge clk); #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/pc_ras_unit.md
PC_RAS_UNIT -- requirements
Module: pc_ras_unit

Interface
REQ-001 Parameter WIDTH, default 16, SHALL set program-counter and target width in bits.
REQ-002 Parameter STEP, default 2, SHALL set the sequential increment added to PC_out.
REQ-003 Parameter RAS_DEPTH, default 4, SHALL set return-address-stack entries (2..16).
REQ-004 Parameter RESET_VEC, default 0, SHALL set the PC_out value loaded on reset.
REQ-005 clk  in  1  sole clock; all state SHALL update on its rising edge.
REQ-006 rst  in  1  asynchronous, active-high reset.
REQ-007 halt_sig  in  1  request to enter HALTED.
REQ-008 resume  in  1  single-cycle pulse; leaves HALTED.
REQ-009 stall  in  1  hold PC and stack this cycle, no FSM change.
REQ-010 branch_en  in  1  load branch_target.
REQ-011 branch_target  in  WIDTH  branch destination.
REQ-012 call_en  in  1  push return address, load call_target.
REQ-013 call_target  in  WIDTH  call destination.
REQ-014 ret_en  in  1  pop stack top into PC.
REQ-015 PC_out  out  WIDTH  current program counter (registered).
REQ-016 ras_empty  out  1  stack holds zero entries.
REQ-017 ras_full  out  1  stack holds RAS_DEPTH entries.
REQ-018 halted  out  1  FSM in HALTED.
REQ-019 fault  out  1  FSM in FAULT.

Function
REQ-020 FSM states SHALL be RUN, HALTED, FAULT; all outputs registered or decoded from registered state.
REQ-021 In RUN, per-cycle priority SHALL be: halt_sig > stall > ret_en > call_en > branch_en > sequential.
REQ-022 RUN with halt_sig=1: next state HALTED, PC_out and stack unchanged.
REQ-023 RUN with stall=1 (halt_sig=0): PC_out, stack, state unchanged; control inputs ignored.
REQ-024 ret_en with stack non-empty: PC_out <= top entry, depth decrements, next cycle.
REQ-025 ret_en with stack empty: next state FAULT, PC_out and stack unchanged.
REQ-026 call_en with stack not full: push (PC_out + STEP) mod 2^WIDTH, PC_out <= call_target.
REQ-027 call_en with stack full: next state FAULT, no push, PC_out unchanged.
REQ-028 call_en and ret_en together: ret_en SHALL win; call_en ignored that cycle.
REQ-029 branch_en alone: PC_out <= branch_target, stack unchanged.
REQ-030 No control asserted: PC_out <= (PC_out + STEP) mod 2^WIDTH; wrap from 2^WIDTH-STEP SHALL yield 0 when STEP divides 2^WIDTH.
REQ-031 All control updates take effect on the first rising edge after sampling (latency 1).
REQ-032 HALTED: PC_out and stack frozen; all controls except resume ignored; resume=1 -> RUN next cycle with no PC change that cycle.
REQ-033 HALTED with halt_sig and resume both 1: resume SHALL win.
REQ-034 FAULT: PC_out and stack frozen; all inputs ignored; exit only via rst.
REQ-035 ras_empty/ras_full SHALL reflect stack depth after each edge; both never 1 together.

Reset
REQ-036 rst=1 SHALL immediately, without clk, force PC_out=RESET_VEC, depth=0, state RUN.
REQ-037 During reset: ras_empty=1, ras_full=0, halted=0, fault=0.
REQ-038 rst asserted mid-call/ret or in HALTED/FAULT SHALL discard the operation and all stack contents.
REQ-039 On rst deassertion, first rising edge SHALL perform normal RUN behaviour.

Verification
REQ-040 Reset, 3 idle edges (defaults) -> PC_out 0, 2, 4, 6; ras_empty=1.
REQ-041 At PC_out=0x0010, call_en, call_target=0x0100; 2 idle edges; ret_en -> PC_out 0x0100, 0x0102, 0x0104, then 0x0012; ras_empty=1.
REQ-042 Four nested calls then a fifth call (RAS_DEPTH=4) -> ras_full=1 after fourth; fault=1, PC_out frozen after fifth; rst clears to PC_out=0, fault=0.
REQ-043 ret_en immediately after reset -> fault=1, PC_out stays 0.
REQ-044 PC_out=0x0004, halt_sig=1 for 3 edges while branch_en=1 -> halted=1, PC_out 0x0004 held; resume pulse -> RUN, next idle edge PC_out=0x0006.
REQ-045 WIDTH=16, branch to 0xFFFE, one idle edge -> PC_out=0x0000; stall=1 with call_en=1 -> no change, ras_empty=1.
